audio_mixer_seq: RTL



---
 rtl/audio_mixer_pkg.sv | 31 +++
 rtl/audio_dc_blocker.sv | 45 ++++
 rtl/audio_mixer_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/audio_mixer_pkg.sv
// Shared types and constants for the sequential audio mixer.
// States, source gains and the per-cycle source index order.
package audio_mixer_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

   localparam logic [7:0] BEEP_GAIN = 8'd96;
   localparam logic [7:0] EAR_GAIN  = 8'd32;
   localparam logic [7:0] MIC_GAIN  = 8'd16;

   localparam logic [2:0] IDX_BEEP       = 3'd0;
   localparam logic [2:0] IDX_EAR        = 3'd1;
   localparam logic [2:0] IDX_MIC        = 3'd2;
   localparam logic [2:0] IDX_AY_A       = 3'd3;
   localparam logic [2:0] IDX_AY_B       = 3'd4;
   localparam logic [2:0] IDX_AY_C_COVOX = 3'd5;
   localparam logic [2:0] LAST_IDX       = 3'd5;

   // Source snapshot taken on the accepted SAMPLE_CE.
   typedef struct packed {
      logic       beeper;
      logic       ear;
      logic       mic;
      logic [7:0] ay_a;
      logic [7:0] ay_b;
      logic [7:0] ay_c;
      logic [7:0] covox;
      logic       mute;
   } src_t;

endpackage

// File: rtl/audio_dc_blocker.sv
// Leaky DC blocker: fixed-point running average of s, output re-centred on
// midscale and clamped. Only used when AUDIO_MIXER_DCBLOCK_EN is defined.
module audio_dc_blocker
   import audio_mixer_pkg::*;
#(
   parameter int MSBO      = 7,
   parameter int ACC_W     = 12,
   parameter int DCB_SHIFT = 8
)(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             upd_i,
   input  logic [ACC_W-1:0] s_i,
   output logic [MSBO:0]    out_o
);

   localparam int AW = ACC_W + DCB_SHIFT;

   logic signed [AW-1:0] avg_q, avg_d;
   logic signed [AW-1:0] s_fx, diff, avg_int;
   logic signed [AW:0]   val;

   // avg carries DCB_SHIFT fraction bits; s is aligned to the same scale.
   always_comb begin
      s_fx    = $signed(AW'(s_i) << DCB_SHIFT);
      diff    = s_fx - avg_q;
      avg_d   = avg_q + (diff >>> DCB_SHIFT);
      avg_int = avg_q >>> DCB_SHIFT;
      val     = (AW+1)'(2**MSBO) + $signed({1'b0, AW'(s_i)}) - (AW+1)'(avg_int);
      if (val < 0)
         out_o = '0;
      else if (val > (AW+1)'(2**(MSBO+1) - 1))
         out_o = '1;
      else
         out_o = val[MSBO:0];
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         avg_q <= '0;
      else if (upd_i)
         avg_q <= avg_d;
   end

endmodule

// File: rtl/audio_mixer_seq.sv
// Sequential mono mixer: one source per clock into an accumulator, then scale,
// saturate and register for the DAC. Optional DC blocker: AUDIO_MIXER_DCBLOCK_EN.
module audio_mixer_seq
   import audio_mixer_pkg::*;
#(
   parameter int MSBO  = 7,
   parameter int ACC_W = 12
`ifdef AUDIO_MIXER_DCBLOCK_EN
   ,
   parameter int DCB_SHIFT = 8
`endif
)(
   input  logic          CLK,
   input  logic          RESET,
   input  logic          SAMPLE_CE,
   input  logic          BEEPER,
   input  logic          EAR,
   input  logic          MIC,
   input  logic [7:0]    AY_A,
   input  logic [7:0]    AY_B,
   input  logic [7:0]    AY_C,
   input  logic [7:0]    COVOX,
   input  logic          MUTE,
   output logic [MSBO:0] DACOUT,
   output logic          VALID,
   output logic          BUSY
);

   state_t           state_q, state_d;
   src_t             src_q, src_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [2:0]       idx_q, idx_d;
   logic [MSBO:0]    dac_q, dac_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic [ACC_W-1:0] term;
   logic [ACC_W-1:0] s;
   logic [MSBO:0]    sat_val;
   logic [MSBO:0]    out_val;
   logic [MSBO:0]    mute_val;

   always_comb begin
      term = '0;
      case (idx_q)
         IDX_BEEP:       term = src_q.beeper ? ACC_W'(BEEP_GAIN) : '0;
         IDX_EAR:        term = src_q.ear    ? ACC_W'(EAR_GAIN)  : '0;
         IDX_MIC:        term = src_q.mic    ? ACC_W'(MIC_GAIN)  : '0;
         IDX_AY_A:       term = ACC_W'(src_q.ay_a);
         IDX_AY_B:       term = ACC_W'(src_q.ay_b);
         IDX_AY_C_COVOX: term = ACC_W'({1'b0, src_q.ay_c} + {1'b0, src_q.covox});
         default:        term = '0;
      endcase
   end

   always_comb begin
      s       = acc_q >> 2;
      sat_val = (|s[ACC_W-1:MSBO+1]) ? '1 : s[MSBO:0];
   end

`ifdef AUDIO_MIXER_DCBLOCK_EN
   // Blocker state advances only on audible passes so MUTE does not bias it.
   audio_dc_blocker #(
      .MSBO      (MSBO),
      .ACC_W     (ACC_W),
      .DCB_SHIFT (DCB_SHIFT)
   ) u_dcb (
      .CLK   (CLK),
      .RESET (RESET),
      .upd_i ((state_q == SAT) && !src_q.mute),
      .s_i   (s),
      .out_o (out_val)
   );
   assign mute_val = {1'b1, {MSBO{1'b0}}};
`else
   assign out_val  = sat_val;
   assign mute_val = '0;
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      dac_d   = dac_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (SAMPLE_CE) begin
               src_d   = '{beeper: BEEPER, ear: EAR, mic: MIC, ay_a: AY_A, ay_b: AY_B,
                           ay_c: AY_C, covox: COVOX, mute: MUTE};
               acc_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_q + term;
            idx_d = idx_q + 3'd1;
            if (idx_q == LAST_IDX)
               state_d = SAT;
         end
         SAT: begin
            dac_d   = src_q.mute ? mute_val : out_val;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         src_q   <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         dac_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         dac_q   <= dac_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign DACOUT = dac_q;
   assign VALID  = valid_q;
   assign BUSY   = busy_q;

endmodule
